// File: rtl/pr_controller.sv
// Partial-reconfiguration scheduler: tracks misses per operator, picks and drains a victim
// region, then runs the PR handshake to load the missing operator there.
module pr_controller #(
  parameter int unsigned OPERATOR_ID_WIDTH = 2,
  parameter int unsigned N_REGIONS         = 4,
  parameter int unsigned QDEPTH            = 4,
  parameter int unsigned MISS_THRESHOLD    = 3,
  parameter int unsigned PR_TIMEOUT        = 1024,
  localparam int unsigned PNTR_BITS = $clog2(QDEPTH),
  localparam int unsigned SW        = OPERATOR_ID_WIDTH + PNTR_BITS,
  localparam int unsigned RW        = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         miss_valid,
  input  logic [OPERATOR_ID_WIDTH-1:0] miss_oid,
  input  logic [N_REGIONS*SW-1:0]      region_stats_in,
  output logic [N_REGIONS-1:0]         region_block,
  output logic                         pr_req,
  output logic [RW-1:0]                pr_region,
  output logic [OPERATOR_ID_WIDTH-1:0] pr_oid,
  input  logic                         pr_done,
  input  logic                         pr_error,
  output logic                         pr_fail,
  output logic                         busy
);

  localparam int unsigned OW     = OPERATOR_ID_WIDTH;
  localparam int unsigned PB     = PNTR_BITS;
  localparam int unsigned N_OIDS = 2 ** OW;
  localparam int unsigned CW     = $clog2(MISS_THRESHOLD + 1);
  localparam int unsigned TW     = (PR_TIMEOUT > 2) ? $clog2(PR_TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_DRAIN, ST_RECONF} state_t;

  state_t                 state;
  logic [N_REGIONS*SW-1:0] stats_q;
  logic [CW-1:0]          miss_cnt [N_OIDS];
  logic [OW-1:0]          target;
  logic                   zero_seen;
  logic [TW-1:0]          tcnt;

  logic                   trig;
  logic [OW-1:0]          trig_oid;
  logic                   resident;
  logic [RW-1:0]          victim;
  logic [PB-1:0]          min_load;
  logic [PB-1:0]          victim_load;
  logic                   timeout;
  logic                   resp_end;
  logic                   clr_en;

  // Lowest operator ID whose miss counter has saturated
  always_comb begin
    trig     = 1'b0;
    trig_oid = '0;
    for (int i = N_OIDS - 1; i >= 0; i--) begin
      if (miss_cnt[i] == CW'(MISS_THRESHOLD)) begin
        trig     = 1'b1;
        trig_oid = OW'(i);
      end
    end
  end

  // Residency check, least-loaded region (strict < keeps the lowest index on ties), victim load
  always_comb begin
    resident    = 1'b0;
    victim      = '0;
    min_load    = stats_q[0 +: PB];
    victim_load = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (stats_q[i*SW+PB +: OW] == target) resident = 1'b1;
      if (stats_q[i*SW +: PB] < min_load) begin
        min_load = stats_q[i*SW +: PB];
        victim   = RW'(i);
      end
      if (RW'(i) == pr_region) victim_load = stats_q[i*SW +: PB];
    end
  end

  assign timeout  = (tcnt == TW'(PR_TIMEOUT - 1));
  assign resp_end = (state == ST_RECONF) && (pr_done || pr_error || timeout);
  assign clr_en   = ((state == ST_SELECT) && resident) || resp_end;
  assign busy     = (state != ST_IDLE);

  // Saturating miss counters; a miss arriving in the clear cycle still counts
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_OIDS; i++) miss_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_OIDS; i++) begin
        if (clr_en && (target == OW'(i))) begin
          miss_cnt[i] <= (miss_valid && (miss_oid == OW'(i))) ? CW'(1) : '0;
        end else if (miss_valid && (miss_oid == OW'(i)) &&
                     (miss_cnt[i] < CW'(MISS_THRESHOLD))) begin
          miss_cnt[i] <= miss_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      stats_q      <= '0;
      target       <= '0;
      zero_seen    <= 1'b0;
      tcnt         <= '0;
      region_block <= '0;
      pr_req       <= 1'b0;
      pr_region    <= '0;
      pr_oid       <= '0;
      pr_fail      <= 1'b0;
    end else begin
      stats_q <= region_stats_in;
      pr_fail <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trig) begin
            target <= trig_oid;
            state  <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (resident) begin
            state <= ST_IDLE;
          end else begin
            pr_region    <= victim;
            pr_oid       <= target;
            region_block <= N_REGIONS'(1) << victim;
            zero_seen    <= 1'b0;
            state        <= ST_DRAIN;
          end
        end
        // Two consecutive empty samples absorb a dispatch already in flight
        ST_DRAIN: begin
          if (victim_load == '0) begin
            if (zero_seen) begin
              pr_req <= 1'b1;
              tcnt   <= '0;
              state  <= ST_RECONF;
            end else begin
              zero_seen <= 1'b1;
            end
          end else begin
            zero_seen <= 1'b0;
          end
        end
        ST_RECONF: begin
          if (resp_end) begin
            pr_fail      <= !pr_done;
            pr_req       <= 1'b0;
            region_block <= '0;
            state        <= ST_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pr_controller.sv
// Self-checking bench for pr_controller: scoreboard of expected PR requests plus directed checks.
module tb_pr_controller;

  localparam int unsigned OW = 2;
  localparam int unsigned NR = 4;
  localparam int unsigned PB = 2;
  localparam int unsigned SW = OW + PB;
  localparam int unsigned TO = 8;
  localparam logic [15:0] STATS_A = 16'b0010_0100_1011_0001;
  localparam logic [15:0] STATS_T = 16'b0001_0101_1001_0001;

  typedef struct packed {
    logic [1:0] region;
    logic [1:0] oid;
  } exp_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          miss_valid = 1'b0;
  logic [OW-1:0] miss_oid = '0;
  logic [15:0]   region_stats_in = '0;
  logic [NR-1:0] region_block;
  logic          pr_req;
  logic [1:0]    pr_region;
  logic [OW-1:0] pr_oid;
  logic          pr_done = 1'b0;
  logic          pr_error = 1'b0;
  logic          pr_fail;
  logic          busy;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic prev_req = 1'b0;

  pr_controller #(
    .OPERATOR_ID_WIDTH(OW), .N_REGIONS(NR), .QDEPTH(4),
    .MISS_THRESHOLD(3), .PR_TIMEOUT(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .miss_valid(miss_valid), .miss_oid(miss_oid),
    .region_stats_in(region_stats_in), .region_block(region_block), .pr_req(pr_req),
    .pr_region(pr_region), .pr_oid(pr_oid), .pr_done(pr_done), .pr_error(pr_error),
    .pr_fail(pr_fail), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent model of victim choice: minimum load, lowest index on ties
  function automatic logic [1:0] model_victim(input logic [15:0] s);
    logic [1:0] v;
    logic [PB-1:0] m;
    v = 2'd0;
    m = s[PB-1:0];
    for (int i = 1; i < NR; i++) begin
      if (s[i*SW +: PB] < m) begin
        m = s[i*SW +: PB];
        v = 2'(i);
      end
    end
    return v;
  endfunction

  // Scoreboard consumer: every rising pr_req must match the next expected request
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_req <= 1'b0;
    end else begin
      check("blk_onehot0", 32'($onehot0(region_block)), 32'd1);
      if (pr_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("pr_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_region", 32'(pr_region), 32'(e.region));
          check("sb_oid", 32'(pr_oid), 32'(e.oid));
        end
      end
      prev_req <= pr_req;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_miss(input logic [OW-1:0] oid);
    miss_valid = 1'b1;
    miss_oid   = oid;
    tick();
    miss_valid = 1'b0;
  endtask

  task automatic expect_pr(input logic [15:0] s, input logic [1:0] oid);
    exp_t e;
    e.region = model_victim(s);
    e.oid    = oid;
    exp_q.push_back(e);
  endtask

  task automatic wait_pr_req();
    int n;
    n = 0;
    while (!pr_req && n < 40) begin
      tick();
      n++;
    end
    check("pr_req_rise", 32'(pr_req), 32'd1);
  endtask

  task automatic pulse_resp(input logic d, input logic e);
    pr_done  = d;
    pr_error = e;
    tick();
    pr_done  = 1'b0;
    pr_error = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    int cnt;

    // 1. Reset with miss activity, then sub-threshold misses
    aresetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      miss_valid = ~miss_valid;
      miss_oid   = 2'd1;
      tick();
      check("rst_outs", {region_block, pr_req, pr_region, pr_oid, pr_fail, busy}, '0);
    end
    miss_valid = 1'b0;
    aresetn    = 1'b1;
    tick();
    send_miss(2'd1);
    send_miss(2'd1);
    repeat (5) tick();
    check("two_miss_busy", 32'(busy), 32'd0);
    check("two_miss_blk", 32'(region_block), 32'd0);

    // 2. Nominal PR
    do_reset();
    region_stats_in = STATS_A;
    expect_pr(STATS_A, 2'd3);
    repeat (3) send_miss(2'd3);
    tick();
    check("nom_busy", 32'(busy), 32'd1);
    tick();
    check("nom_blk", 32'(region_block), 32'b0100);
    wait_pr_req();
    check("nom_region", 32'(pr_region), 32'd2);
    check("nom_oid", 32'(pr_oid), 32'd3);
    pulse_resp(1'b1, 1'b0);
    check("nom_done_blk", 32'(region_block), 32'd0);
    check("nom_done_req", 32'(pr_req), 32'd0);
    check("nom_done_busy", 32'(busy), 32'd0);
    check("nom_done_fail", 32'(pr_fail), 32'd0);

    // 3. Tie on load and drain qualification
    do_reset();
    region_stats_in = STATS_T;
    expect_pr(STATS_T, 2'd3);
    repeat (3) send_miss(2'd3);
    tick();
    tick();
    check("tie_blk", 32'(region_block), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("drain_hold", 32'(pr_req), 32'd0);
    end
    region_stats_in[3:0] = 4'b0000;
    tick();
    check("drain_z0", 32'(pr_req), 32'd0);
    tick();
    check("drain_z1", 32'(pr_req), 32'd0);
    tick();
    check("drain_go", 32'(pr_req), 32'd1);
    check("drain_region", 32'(pr_region), 32'd0);
    pulse_resp(1'b1, 1'b0);
    check("tie_done_blk", 32'(region_block), 32'd0);

    // 4. Target already resident: no PR
    do_reset();
    region_stats_in = STATS_A;
    repeat (3) send_miss(2'd2);
    tick();
    check("res_select", 32'(busy), 32'd1);
    tick();
    check("res_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("res_noblk", {region_block, pr_req}, '0);
      tick();
    end
    send_miss(2'd2);
    repeat (4) begin
      check("res_retrig", 32'(busy), 32'd0);
      tick();
    end

    // 5a. Timeout
    do_reset();
    region_stats_in = STATS_A;
    expect_pr(STATS_A, 2'd3);
    repeat (3) send_miss(2'd3);
    wait_pr_req();
    cnt = 0;
    while (pr_req && cnt < 20) begin
      check("to_nofail", 32'(pr_fail), 32'd0);
      cnt++;
      tick();
    end
    check("to_req_cycles", 32'(cnt), 32'(TO));
    check("to_fail", 32'(pr_fail), 32'd1);
    check("to_blk", 32'(region_block), 32'd0);
    tick();
    check("to_fail_pulse", 32'(pr_fail), 32'd0);

    // 5b. Done and error together: done wins
    expect_pr(STATS_A, 2'd3);
    repeat (3) send_miss(2'd3);
    wait_pr_req();
    pulse_resp(1'b1, 1'b1);
    check("both_fail", 32'(pr_fail), 32'd0);
    check("both_req", 32'(pr_req), 32'd0);
    tick();
    check("both_fail2", 32'(pr_fail), 32'd0);

    // 5c. Error alone
    expect_pr(STATS_A, 2'd3);
    repeat (3) send_miss(2'd3);
    wait_pr_req();
    pulse_resp(1'b0, 1'b1);
    check("err_fail", 32'(pr_fail), 32'd1);
    check("err_blk", 32'(region_block), 32'd0);
    tick();
    check("err_fail_pulse", 32'(pr_fail), 32'd0);

    // 6. Trigger queued while busy, then async reset during drain
    do_reset();
    region_stats_in = STATS_A;
    expect_pr(STATS_A, 2'd3);
    repeat (3) send_miss(2'd3);
    wait_pr_req();
    repeat (3) send_miss(2'd1);
    check("q_still_req", 32'(pr_req), 32'd1);
    pulse_resp(1'b1, 1'b0);
    check("q_idle", 32'(busy), 32'd0);
    tick();
    check("q_select", 32'(busy), 32'd1);
    tick();
    check("q_abort", 32'(busy), 32'd0);
    check("q_noblk", 32'(region_block), 32'd0);

    region_stats_in = STATS_T;
    tick();
    repeat (3) send_miss(2'd3);
    tick();
    tick();
    check("ar_drain_blk", 32'(region_block), 32'b0001);
    #2;
    aresetn = 1'b0;
    #1;
    check("ar_blk", 32'(region_block), 32'd0);
    check("ar_req", 32'(pr_req), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    tick();
    aresetn = 1'b1;
    repeat (4) tick();
    check("ar_quiet", {region_block, pr_req, busy}, '0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
